cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture_pkg.sv | 34 +++
 rtl/cam_byte_assembler.sv | 47 ++++
 rtl/cam_capture.sv | 161 ++++++++++++++++
 tb/tb_cam_capture.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
`default_nettype none
//============================================================================
// Package  : cam_capture_pkg
// Brief    : Shared FSM encoding, RGB444 field positions and default geometry
//            for the camera capture path.
// Revision : 1.0 - initial release
//============================================================================
package cam_capture_pkg;

    localparam int c_H_PIXELS_DEF = 640;
    localparam int c_V_LINES_DEF  = 480;
    localparam int c_ADDR_W_DEF   = 19;

    localparam int             c_ST_W       = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_VS = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_CAPTURE = 2'd2;

    // Frame-buffer pixel {R,G,B}, matching the VGA pixel input.
    localparam int c_CH_W  = 4;
    localparam int c_PIX_W = 3 * c_CH_W;
    localparam int c_R_LSB = 8;
    localparam int c_G_LSB = 4;
    localparam int c_B_LSB = 0;

    // Camera RGB444 byte layout: byte0 = {xxxx,R}, byte1 = {G,B}.
    localparam int c_B0_R_LSB = 0;
    localparam int c_B1_G_LSB = 4;
    localparam int c_B1_B_LSB = 0;

    typedef logic [c_PIX_W-1:0] pixel_t;

endpackage : cam_capture_pkg
`default_nettype wire

// File: rtl/cam_byte_assembler.sv
`default_nettype none
//============================================================================
// Module   : cam_byte_assembler
// Brief    : Pairs camera bytes into one RGB444 pixel using a byte-phase
//            toggle; a cleared phase discards any dangling byte0.
// Revision : 1.0 - initial release
//============================================================================
module cam_byte_assembler
    import cam_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_accept,
    input  logic [7:0] i_byte,
    output logic       o_pix_valid,
    output pixel_t     o_pixel
);

    logic              r_phase;
    logic [c_CH_W-1:0] r_red;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= 1'b0;
            r_red   <= '0;
        end else if (i_clear) begin
            r_phase <= 1'b0;
        end else if (i_accept) begin
            if (!r_phase) begin
                r_red <= i_byte[c_B0_R_LSB +: c_CH_W];
            end
            r_phase <= ~r_phase;
        end
    end

    // The pixel completes combinationally on byte1; the caller registers it.
    always_comb begin
        o_pix_valid                    = i_accept & r_phase;
        o_pixel                        = '0;
        o_pixel[c_R_LSB +: c_CH_W]     = r_red;
        o_pixel[c_G_LSB +: c_CH_W]     = i_byte[c_B1_G_LSB +: c_CH_W];
        o_pixel[c_B_LSB +: c_CH_W]     = i_byte[c_B1_B_LSB +: c_CH_W];
    end

endmodule : cam_byte_assembler
`default_nettype wire

// File: rtl/cam_capture.sv
`default_nettype none
//============================================================================
// Module   : cam_capture
// Brief    : Captures one RGB444 camera frame per VSYNC into a frame buffer.
// Revision : 1.0 - initial release
//============================================================================
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int H_PIXELS = c_H_PIXELS_DEF,
    parameter int V_LINES  = c_V_LINES_DEF,
    parameter int ADDR_W   = c_ADDR_W_DEF
) (
    input  logic              CLK_25_I,
    input  logic              RST_N_I,
    input  logic              ENABLE_I,
    input  logic              PCLK_EN_I,
    input  logic              CAM_VSYNC_I,
    input  logic              CAM_HREF_I,
    input  logic [7:0]        CAM_DATA_I,
    output logic              BRAM_WE_O,
    output logic [ADDR_W-1:0] BRAM_ADDR_O,
    output logic [11:0]       BRAM_DATA_O,
    output logic              FRAME_DONE_O,
    output logic              BUSY_O
);

    localparam int                 c_COL_W  = $clog2(H_PIXELS + 1);
    localparam int                 c_LINE_W = $clog2(V_LINES + 1);
    localparam logic [c_COL_W-1:0] c_H_COL  = c_COL_W'(H_PIXELS);
    localparam logic [c_LINE_W-1:0] c_V_LINE = c_LINE_W'(V_LINES);
    localparam logic [ADDR_W-1:0]  c_H_STEP = ADDR_W'(H_PIXELS);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_next_state;
    logic                r_vsync_q;
    logic                r_href_q;
    logic                w_vs_fall;
    logic                w_vs_rise;
    logic                w_href_fall;
    logic                w_capture;
    logic                w_frame_start;
    logic                w_frame_end;
    logic                w_accept;
    logic                w_pix_valid;
    pixel_t              w_pixel;
    logic                w_write;
    logic                w_line_adv;
    logic [c_COL_W-1:0]  r_col;
    logic [c_LINE_W-1:0] r_line;
    logic                r_line_used;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    pixel_t              r_data;
    logic                r_done;

    assign w_vs_fall   = r_vsync_q & ~CAM_VSYNC_I;
    assign w_vs_rise   = ~r_vsync_q & CAM_VSYNC_I;
    assign w_href_fall = r_href_q & ~CAM_HREF_I;

    always_ff @(posedge CLK_25_I) begin
        if (!RST_N_I) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:    if (ENABLE_I)  w_next_state = c_ST_WAIT_VS;
            c_ST_WAIT_VS: if (w_vs_fall) w_next_state = c_ST_CAPTURE;
            c_ST_CAPTURE: if (w_vs_rise) w_next_state = ENABLE_I ? c_ST_WAIT_VS : c_ST_IDLE;
            default:                     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_capture     = (r_state == c_ST_CAPTURE);
        w_frame_start = (r_state == c_ST_WAIT_VS) & w_vs_fall;
        w_frame_end   = w_capture & w_vs_rise;
        BUSY_O        = w_capture;
    end

    // A byte arriving with the closing VSYNC edge belongs to no frame.
    assign w_accept   = w_capture & ~w_vs_rise & PCLK_EN_I & CAM_HREF_I;
    assign w_write    = w_pix_valid & (r_col < c_H_COL) & (r_line < c_V_LINE);
    assign w_line_adv = w_capture & w_href_fall & r_line_used & (r_line < c_V_LINE);

    cam_byte_assembler u_byte_asm (
        .clk         (CLK_25_I),
        .rst_n       (RST_N_I),
        .i_clear     (w_href_fall | w_frame_start | w_frame_end),
        .i_accept    (w_accept),
        .i_byte      (CAM_DATA_I),
        .o_pix_valid (w_pix_valid),
        .o_pixel     (w_pixel)
    );

    always_ff @(posedge CLK_25_I) begin
        if (!RST_N_I) begin
            r_vsync_q <= 1'b0;
            r_href_q  <= 1'b0;
        end else begin
            r_vsync_q <= CAM_VSYNC_I;
            r_href_q  <= CAM_HREF_I;
        end
    end

    // Re-basing the pointer per line keeps short lines from shifting later ones.
    always_ff @(posedge CLK_25_I) begin
        if (!RST_N_I || w_frame_start) begin
            r_col       <= '0;
            r_line      <= '0;
            r_line_used <= 1'b0;
            r_base      <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_href_fall) begin
                r_col       <= '0;
                r_line_used <= 1'b0;
            end else begin
                if (w_accept)                         r_line_used <= 1'b1;
                if (w_pix_valid && (r_col < c_H_COL)) r_col       <= r_col + 1'b1;
            end
            if (w_line_adv) begin
                r_line <= r_line + 1'b1;
                r_base <= r_base + c_H_STEP;
                r_ptr  <= r_base + c_H_STEP;
            end else if (w_write) begin
                r_ptr  <= r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_25_I) begin
        if (!RST_N_I) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
            r_done <= 1'b0;
        end else begin
            r_we   <= w_write;
            r_done <= w_frame_end;
            if (w_write) begin
                r_addr <= r_ptr;
                r_data <= w_pixel;
            end
        end
    end

    assign BRAM_WE_O    = r_we;
    assign BRAM_ADDR_O  = r_addr;
    assign BRAM_DATA_O  = r_data;
    assign FRAME_DONE_O = r_done;

endmodule : cam_capture
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
//============================================================================
// Module   : tb_cam_capture
// Brief    : Self-checking bench for cam_capture with a frame-level model.
// Revision : 1.0 - initial release
//============================================================================
module tb_cam_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n, en, pclk, vs, href;
    logic [7:0]    data;
    logic          we, done, busy;
    logic [AW-1:0] addr;
    logic [11:0]   pdata;

    int n_vec = 0;
    int n_bad = 0;

    // Observed per-scenario totals, gathered by the compare process.
    int          obs_wr, obs_done, obs_abc, obs_max;
    logic [31:0] obs_mask;

    // Reference model: mode 0 idle, 1 armed, 2 capturing.
    int          m_mode, m_line, m_col;
    bit          m_pvs, m_phref, m_half, m_used;
    logic [3:0]  m_red;
    logic        exp_we, exp_done, exp_busy;
    int          exp_addr;
    logic [11:0] exp_data;

    cam_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .CLK_25_I     (clk),
        .RST_N_I      (rst_n),
        .ENABLE_I     (en),
        .PCLK_EN_I    (pclk),
        .CAM_VSYNC_I  (vs),
        .CAM_HREF_I   (href),
        .CAM_DATA_I   (data),
        .BRAM_WE_O    (we),
        .BRAM_ADDR_O  (addr),
        .BRAM_DATA_O  (pdata),
        .FRAME_DONE_O (done),
        .BUSY_O       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit vr, vf, hf;
        if (!rst_n) begin
            m_mode = 0; m_pvs = 0; m_phref = 0; m_half = 0; m_used = 0;
            m_line = 0; m_col = 0;
            exp_we = 0; exp_done = 0; exp_busy = 0; exp_addr = 0; exp_data = '0;
            return;
        end
        vr = !m_pvs && vs;
        vf = m_pvs && !vs;
        hf = m_phref && !href;
        exp_we   = 0;
        exp_done = 0;
        case (m_mode)
            0: if (en) m_mode = 1;
            1: if (vf) begin
                   m_mode = 2; m_line = 0; m_col = 0; m_half = 0; m_used = 0;
               end
            default: begin
                if (vr) begin
                    exp_done = 1;
                    m_mode   = en ? 1 : 0;
                end else if (hf) begin
                    if (m_used && m_line < V) m_line++;
                    m_used = 0; m_half = 0; m_col = 0;
                end else if (pclk && href) begin
                    m_used = 1;
                    if (!m_half) begin
                        m_half = 1;
                        m_red  = data[3:0];
                    end else begin
                        m_half = 0;
                        if (m_col < H && m_line < V) begin
                            exp_we   = 1;
                            exp_addr = m_line * H + m_col;
                            exp_data = {m_red, data};
                        end
                        m_col++;
                    end
                end
            end
        endcase
        exp_busy = (m_mode == 2);
        m_pvs    = vs;
        m_phref  = href;
    endtask

    initial begin
        m_mode = 0; m_pvs = 0; m_phref = 0; m_half = 0; m_used = 0;
        m_line = 0; m_col = 0; m_red = '0;
        exp_we = 0; exp_done = 0; exp_busy = 0; exp_addr = 0; exp_data = '0;
        forever begin
            @(negedge clk);
            chk("we", 32'(we), 32'(exp_we));
            chk("frame_done", 32'(done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_we) begin
                chk("addr", 32'(addr), 32'(exp_addr));
                chk("data", 32'(pdata), 32'(exp_data));
            end
            if (we === 1'b1) begin
                obs_wr++;
                if (addr < 32) obs_mask[addr[4:0]] = 1'b1;
                if (int'(addr) > obs_max) obs_max = int'(addr);
                if (pdata == 12'hABC) obs_abc++;
            end
            if (done === 1'b1) obs_done++;
            model_step();
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, %0d vectors so far", n_vec);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_obs();
        obs_wr = 0; obs_done = 0; obs_abc = 0; obs_max = 0; obs_mask = '0;
    endtask

    task automatic send_bytes(input int n, input bit pat);
        for (int i = 0; i < n; i++) begin
            if (!pat) repeat ($urandom_range(0, 2)) tick();
            pclk = 1'b1;
            data = pat ? (((i % 2) != 0) ? 8'hBC : 8'h0A) : 8'($urandom);
            tick();
            pclk = 1'b0;
        end
    endtask

    task automatic send_line(input int n, input bit pat);
        href = 1'b1;
        tick();
        send_bytes(n, pat);
        href = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_frame(input int nl, input int nb0, input int nb, input bit pat, input int drop);
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < nl; l++) begin
            send_line((l == 0) ? nb0 : nb, pat);
            if (l == drop) en = 1'b0;
        end
        vs = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; pclk = 1'b0; vs = 1'b1; href = 1'b0; data = '0;
        clr_obs();
        repeat (3) tick();
        chk("reset_we", 32'(we), 0);
        chk("reset_addr", 32'(addr), 0);
        chk("reset_data", 32'(pdata), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Basic 4x2 frame of 0xABC pixels.
        clr_obs();
        en = 1'b1;
        tick();
        do_frame(2, 8, 8, 1, -1);
        repeat (3) tick();
        chk("basic_writes", 32'(obs_wr), 8);
        chk("basic_addr_set", obs_mask, 32'hFF);
        chk("basic_data_abc", 32'(obs_abc), 8);
        chk("basic_done", 32'(obs_done), 1);

        // Arming while VSYNC is low mid-frame must wait for the next fall.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b0; vs = 1'b0;
        tick();
        clr_obs();
        en = 1'b1;
        tick();
        send_line(8, 1);
        send_line(8, 1);
        chk("midarm_no_writes", 32'(obs_wr), 0);
        do_frame(2, 8, 8, 1, -1);
        repeat (3) tick();
        chk("midarm_writes", 32'(obs_wr), 8);
        chk("midarm_addr_set", obs_mask, 32'hFF);

        // Odd-length short line, then a full line starting at address H.
        clr_obs();
        do_frame(2, 5, 8, 1, -1);
        repeat (3) tick();
        chk("short_writes", 32'(obs_wr), 6);
        chk("short_addr_set", obs_mask, 32'hF3);

        // Oversized frame is clipped to the buffer.
        clr_obs();
        do_frame(3, 12, 12, 1, -1);
        repeat (3) tick();
        chk("clip_writes", 32'(obs_wr), 8);
        chk("clip_max_addr", 32'(obs_max), 7);
        chk("clip_addr_set", obs_mask, 32'hFF);

        // Reset after three pixels abandons the frame.
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        repeat (2) tick();
        href = 1'b1;
        tick();
        send_bytes(6, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_we", 32'(we), 0);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_data", 32'(pdata), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_busy", 32'(busy), 0);
        clr_obs();
        send_bytes(2, 1);
        href = 1'b0;
        repeat (2) tick();
        send_line(8, 1);
        vs = 1'b1;
        repeat (4) tick();
        chk("midrst_no_done", 32'(obs_done), 0);
        chk("midrst_no_writes", 32'(obs_wr), 0);
        clr_obs();
        do_frame(2, 8, 8, 1, -1);
        repeat (3) tick();
        chk("restart_writes", 32'(obs_wr), 8);
        chk("restart_addr_set", obs_mask, 32'hFF);

        // Dropping ENABLE mid-frame lets the frame finish, then goes idle.
        clr_obs();
        do_frame(2, 8, 8, 1, 0);
        repeat (3) tick();
        chk("drop_writes", 32'(obs_wr), 8);
        chk("drop_done", 32'(obs_done), 1);
        chk("drop_busy", 32'(busy), 0);
        clr_obs();
        do_frame(2, 8, 8, 1, -1);
        repeat (3) tick();
        chk("idle_no_writes", 32'(obs_wr), 0);

        // Randomised frames checked against the model every cycle.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 14) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            en = ($urandom_range(0, 3) != 0);
            tick();
            vs = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            vs = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            for (int l = $urandom_range(0, 4); l > 0; l--) begin
                if (l == 1 && $urandom_range(0, 5) == 0) begin
                    href = 1'b1;
                    tick();
                    send_bytes($urandom_range(0, 13), 0);
                    vs = 1'b1;
                    tick();
                    href = 1'b0;
                    tick();
                end else begin
                    send_line($urandom_range(0, 13), 0);
                end
                if ($urandom_range(0, 7) == 0) en = ~en;
            end
            vs = 1'b1;
            tick();
        end

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cam_capture
`default_nettype wire
